// File: rtl/hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv
// Description : Multi-cycle unsigned MULTU/DIVU unit owning the HI/LO
//               registers. One result bit per cycle, WIDTH cycles per op.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] c_CNT_LAST = 6'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [5:0]       r_cnt;
    logic             r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    // Upper working half: product accumulator (MULTU) or remainder (DIVU).
    // The transient carry / extra remainder bit lives only in the
    // combinational step below, so the stored part is WIDTH bits.
    logic [WIDTH-1:0] r_acc;
    // Lower working half: multiplier shift register or quotient shift register.
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH-1:0] w_mul_sh;
    logic [WIDTH:0]   w_shrem;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_div_acc;
    logic [WIDTH-1:0] w_div_sh;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_sh_nxt;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_cnt == c_CNT_LAST);

    // Shift-add step: add multiplicand into the upper half, then shift
    // {carry, acc, mplier} right by one.
    assign w_addend  = r_sh[0] ? r_a : '0;
    assign w_sum     = {1'b0, r_acc} + {1'b0, w_addend};
    assign w_mul_acc = w_sum[WIDTH:1];
    assign w_mul_sh  = {w_sum[0], r_sh[WIDTH-1:1]};

    // Restoring divide step: shift {rem, quot} left, trial-subtract divisor.
    // A zero divisor always "fits", giving all-ones quotient and rem = a.
    assign w_shrem   = {r_acc, r_sh[WIDTH-1]};
    assign w_ge      = (w_shrem >= {1'b0, r_b});
    assign w_diff    = w_shrem[WIDTH-1:0] - r_b;
    assign w_div_acc = w_ge ? w_diff : w_shrem[WIDTH-1:0];
    assign w_div_sh  = {r_sh[WIDTH-2:0], w_ge};

    assign w_acc_nxt = r_op ? w_div_acc : w_mul_acc;
    assign w_sh_nxt  = r_op ? w_div_sh  : w_mul_sh;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: accept from IDLE, leave RUN after the last iteration
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand latch on accept, one iteration per RUN cycle,
    // HI/LO commit and done pulse on the final iteration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_op   <= 1'b0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_sh   <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_op  <= op;
                r_a   <= a;
                r_b   <= b;
                r_cnt <= '0;
                r_acc <= '0;
                r_sh  <= op ? a : b;
            end else if (r_state == S_RUN) begin
                r_acc <= w_acc_nxt;
                r_sh  <= w_sh_nxt;
                r_cnt <= r_cnt + 6'd1;
                if (w_last) begin
                    r_hi   <= w_acc_nxt;
                    r_lo   <= w_sh_nxt;
                    r_done <= 1'b1;
                    r_cnt  <= '0;
                end
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multi-cycle unsigned multiply/divide unit that owns the HI and LO registers of the single-cycle MIPS datapath. It is the execution-side responder to the decoder's `ToLH` request for MULTU and DIVU. It computes a 64-bit product, or a 32-bit quotient and remainder, over 32 iterations while holding `busy` to stall the PC. It drives the HI/LO values that MFHI and MFLO select through `LHToReg`.

## Interface
- `WIDTH`, default 32: operand width. HI, LO and the iteration count all equal `WIDTH`.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `start` input 1: operation request, driven from the decoder's `ToLH`.
- `op` input 1: operation select. 0 = MULTU, 1 = DIVU. Driven from instruction `Func[1]`: 25 → 0, 27 → 1.
- `a` input WIDTH: rs operand. Multiplicand or dividend.
- `b` input WIDTH: rt operand. Multiplier or divisor.
- `busy` output 1: high while an operation is in flight. PC/regfile stall.
- `done` output 1: one-cycle pulse when HI/LO have just been updated.
- `hi` output WIDTH: HI register. MULTU: product[63:32]. DIVU: remainder.
- `lo` output WIDTH: LO register. MULTU: product[31:0]. DIVU: quotient.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1. 6-bit iteration counter `cnt` runs 0..WIDTH-1.
- Acceptance:
  - IDLE and `start`=1 at an edge: latch `a`, `b` and `op`, clear `cnt`, go to RUN.
  - `hi` and `lo` keep their old values throughout RUN.
- MULTU, shift-add with a WIDTH+1-bit accumulator and a WIDTH-bit multiplier shift register. Each iteration:
  - if multiplier LSB = 1, add the latched `a` to the accumulator upper half, keeping the carry;
  - shift {carry, acc, mplier} right 1.
- DIVU, restoring. Remainder register is WIDTH+1 bits and the quotient shift register is WIDTH bits. Each iteration:
  - shift {rem, quot} left 1;
  - trial-subtract `b`;
  - if the result is non-negative, keep it and set quot LSB to 1; otherwise restore and set quot LSB to 0.
- Divide by zero (`b`=0), a decided result:
  - `lo`=all ones and `hi`=`a`. This falls out of the restoring algorithm and needs no special casing.
  - Still takes the full WIDTH iterations.
- Completion:
  - On the iteration with `cnt`=WIDTH-1, write the final values to `hi`/`lo`, return to IDLE, and assert `done` for the following cycle.
- `start` while in RUN is ignored. It is not queued. The controller guarantees the stall, and the block must not depend on that.
- `start` with `op` sampled as X is not checked. Only `op` at the acceptance edge matters; later changes to `a`, `b` and `op` have no effect.
- `rst` asserted at any time:
  - immediately forces IDLE, `cnt`=0, `busy`=0, `done`=0, `hi`=0, `lo`=0;
  - discards any in-flight operation.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0.
- `busy` is a registered output, not a combinational function of `start`. The datapath ORs `start` into the stall so the MULTU/DIVU instruction itself does not retire twice.
- Start accepted at edge k:
  - `busy`=1 from just after k.
  - Iterations run on edges k+1 … k+WIDTH.
  - `hi`/`lo` update at edge k+WIDTH.
  - `busy`=0 and `done`=1 just after k+WIDTH, for one cycle.
- Latency is WIDTH cycles (32) from acceptance to valid HI/LO.
- Back-to-back operations:
  - `start`=1 at edge k+WIDTH is ignored, because state is still RUN before that edge.
  - The earliest next acceptance is edge k+WIDTH+1, where `done`=1 and `start`=1 together are legal.
- MFHI/MFLO reading during RUN sees the previous HI/LO values.

## Test plan
- Reset, then MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF accepted at edge k → `busy` high for exactly 32 cycles; at k+32 `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` pulses once.
- DIVU with a=100, b=7 → `lo`=14, `hi`=2 after 32 cycles. Then DIVU with a=0x80000000, b=0x10 → `lo`=0x08000000, `hi`=0.
- DIVU with a=0x12345678, b=0 → `lo`=0xFFFFFFFF, `hi`=0x12345678 with 32-cycle latency.
- Pulse `start` again with different operands at cycle 5 of a run, and change `a`/`b` mid-run → result matches the first operands only; no second `done`. Then `start` at the `done` cycle → accepted, and completes 32 cycles later.
- Assert `rst` asynchronously (between edges) at iteration 17 of a MULTU → `busy`, `done`, `hi` and `lo` go to 0 without waiting for an edge. After release, a new MULTU 3×5 gives `lo`=15, `hi`=0.
- Random compare: 1000 MULTU/DIVU operations with random 32-bit operands (including b=1 and a<b) against the reference model → `hi`/`lo` exact match, and every `done` exactly 32 cycles after acceptance.
